uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd2_500_000; it is the inter-byte timeout in clk cycles (100 ms at 25 MHz).
REQ-002 SHALL have port clk, input, 1: the 25 MHz system clock; single clock domain.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port rx_valid, input, 1: one-cycle pulse from uart_rx indicating that rx_data is valid.
REQ-005 SHALL have port rx_data, input, 8: the received byte.
REQ-006 SHALL have port tx_start, output, 1: one-cycle pulse to UART_TX.
REQ-007 SHALL have port tx_data, output, 8: the byte to transmit; held stable until tx_done.
REQ-008 SHALL have port tx_active, input, 1: UART_TX busy.
REQ-009 SHALL have port tx_done, input, 1: one-cycle pulse when UART_TX completes a byte.
REQ-010 SHALL have port bus_addr, output, 16: CPU-space address.
REQ-011 SHALL have port bus_wdata, output, 8: write data.
REQ-012 SHALL have port bus_req, output, 1: bus request, held until bus_ack.
REQ-013 SHALL have port bus_we, output, 1: 1 = write, 0 = read; valid while bus_req is high.
REQ-014 SHALL have port bus_ack, input, 1: one-cycle pulse that completes a bus transfer.
REQ-015 SHALL have port bus_rdata, input, 8: read data, valid in the bus_ack cycle.
REQ-016 SHALL have port cpu_halt, output, 1: holds the 6502 and PPU in reset and grants the bus to this block.
REQ-017 SHALL have port cmd_err, output, 1: one-cycle pulse on a dropped byte or a timeout.

Function
REQ-018 SHALL decode the opcodes 0x02 WRITE (addr_hi, addr_lo, data), 0x03 READ (addr_hi, addr_lo), 0x06 HALT and 0x07 RUN.
REQ-019 SHALL use the FSM states IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX_SEND and TX_WAIT.
REQ-020 SHALL move from IDLE to ADDR_HI on rx_valid with byte 0x02 or 0x03, latching the opcode.
REQ-021 SHALL stay in IDLE for any byte other than 0x02/0x03/0x06/0x07, with no output change and no cmd_err.
REQ-022 SHALL, on HALT, set cpu_halt to 1 on the cycle after the rx_valid and remain in IDLE; on RUN, clear cpu_halt the same way; a repeated HALT or RUN is idempotent.
REQ-023 SHALL latch addr_hi into bus_addr[15:8] in ADDR_HI and addr_lo into bus_addr[7:0] in ADDR_LO.
REQ-024 SHALL go from ADDR_LO to DATA when the opcode is WRITE, and to BUS when it is READ.
REQ-025 SHALL latch bus_wdata in DATA and then enter BUS.
REQ-026 SHALL assert bus_req in the cycle after entering BUS, holding bus_req, bus_we, bus_addr and bus_wdata stable until bus_ack, and SHALL deassert bus_req in the cycle after bus_ack.
REQ-027 SHALL, on a WRITE bus_ack, return to IDLE.
REQ-028 SHALL, on a READ bus_ack, capture bus_rdata into tx_data and enter TX_SEND.
REQ-029 SHALL pulse tx_start for exactly one cycle in TX_SEND, only when tx_active is 0 (waiting otherwise), and then enter TX_WAIT.
REQ-030 SHALL return from TX_WAIT to IDLE on tx_done.
REQ-031 SHALL, when cpu_halt is 0, drop WRITE without issuing bus_req, and answer READ with tx_data 0xFF without issuing bus_req.
REQ-032 SHALL drop any rx_valid arriving in BUS, TX_SEND or TX_WAIT and pulse cmd_err.
REQ-033 SHALL count the cycles spent in ADDR_HI, ADDR_LO or DATA without rx_valid; when the count reaches TIMEOUT_CYCLES it SHALL abandon the command, return to IDLE and pulse cmd_err; the counter clears on every rx_valid.
REQ-034 SHALL not time out in BUS, TX_SEND or TX_WAIT; a stalled bus_ack holds BUS indefinitely.
REQ-035 SHALL use 16-bit address latching with no arithmetic and no auto-increment.

Reset
REQ-036 SHALL, while rst is 0 at a clk edge, set the state to IDLE, and set tx_start, bus_req, bus_we and cmd_err to 0; bus_addr to 0x0000; bus_wdata and tx_data to 0x00; the timeout counter to 0.
REQ-037 SHALL set cpu_halt to 0 on reset, so the CPU runs after reset.
REQ-038 SHALL, on a reset in the middle of a command, abandon the command; an in-flight bus_req drops on the reset cycle and a late bus_ack is ignored.

Structure
REQ-039 SHALL take the opcode constants (CMD_WRITE, CMD_READ, CMD_HALT, CMD_RUN) and the FSM state enum from package ie_defs.
REQ-040 SHALL put the inter-byte timeout in one sub-module, uart_byte_timer (inputs clk, rst, enable, kick; output expired).

Verification
REQ-041 SHALL verify: HALT 0x06 sent over uart_rx -> cpu_halt goes to 1; RUN 0x07 sent -> cpu_halt goes to 0.
REQ-042 SHALL verify: with the CPU halted, bytes 02 80 00 A9 -> one bus_req with bus_we 1, bus_addr 0x8000 and bus_wdata 0xA9; bus_ack after 3 cycles -> IDLE.
REQ-043 SHALL verify: with the CPU halted, bytes 03 20 07 and bus_rdata 0x5C at ack -> a single tx_start and a UART byte 0x5C received.
REQ-044 SHALL verify: with the CPU running, 03 00 10 -> no bus_req and reply 0xFF; 02 00 10 33 -> no bus_req.
REQ-045 SHALL verify: 02 80 followed by silence for TIMEOUT_CYCLES (override to 100) -> cmd_err pulse and IDLE; a following 06 sets cpu_halt.
REQ-046 SHALL verify: byte 0x55, and rst asserted during the READ TX_WAIT -> 0x55 ignored; reset returns all outputs to their reset values, and a following 02 00 00 11 completes normally.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// ie_defs: opcode constants and FSM state encoding for the UART command controller
package ie_defs;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h06;
  localparam logic [7:0] CMD_RUN   = 8'h07;
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX_SEND, TX_WAIT} state_t;
endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: UART byte stream, TX handshake, CPU bus and CPU control signals
interface uart_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_active;
  logic       tx_done;
  logic [15:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_req;
  logic       bus_we;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       cpu_halt;
  logic       cmd_err;
  modport master (
    input  rx_valid, rx_data, tx_active, tx_done, bus_ack, bus_rdata,
    output tx_start, tx_data, bus_addr, bus_wdata, bus_req, bus_we, cpu_halt, cmd_err
  );
  modport slave (
    output rx_valid, rx_data, tx_active, tx_done, bus_ack, bus_rdata,
    input  tx_start, tx_data, bus_addr, bus_wdata, bus_req, bus_we, cpu_halt, cmd_err
  );
endinterface

// File: rtl/uart_cmd_ctrl_byte_timer.sv
// uart_byte_timer: inter-byte timeout, expires after TIMEOUT_CYCLES enabled cycles without a kick
module uart_byte_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);
  logic [31:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst || !enable || kick) r_cnt <= '0;
    else if (!expired) r_cnt <= r_cnt + 32'd1;
  end
  assign expired = enable && !kick && (r_cnt == TIMEOUT_CYCLES - 32'd1);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART command bytes into CPU bus reads/writes and halt/run control
module uart_cmd_ctrl
  import ie_defs::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_500_000
) (
  input logic clk,
  input logic rst,
  uart_cmd_ctrl_if.master b
);
  state_t      r_state;
  logic [7:0]  r_op;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic [15:0] r_bus_addr;
  logic [7:0]  r_bus_wdata;
  logic        r_bus_req;
  logic        r_bus_we;
  logic        r_cpu_halt;
  logic        r_cmd_err;
  logic        w_expired;
  logic        w_in_cmd;
  logic        w_busy;
  assign w_in_cmd = r_state inside {ADDR_HI, ADDR_LO, DATA};
  assign w_busy   = r_state inside {BUS, TX_SEND, TX_WAIT};
  uart_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .enable(w_in_cmd), .kick(b.rx_valid), .expired(w_expired)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_op        <= 8'h00;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_bus_addr  <= 16'h0000;
      r_bus_wdata <= 8'h00;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_cpu_halt  <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_cmd_err  <= b.rx_valid && w_busy;
      case (r_state)
        IDLE: if (b.rx_valid) begin
          if (b.rx_data == CMD_HALT) r_cpu_halt <= 1'b1;
          else if (b.rx_data == CMD_RUN) r_cpu_halt <= 1'b0;
          else if (b.rx_data == CMD_WRITE || b.rx_data == CMD_READ) begin
            r_op    <= b.rx_data;
            r_state <= ADDR_HI;
          end
        end
        ADDR_HI: if (b.rx_valid) begin
          r_bus_addr[15:8] <= b.rx_data;
          r_state          <= ADDR_LO;
        end else if (w_expired) begin
          r_state   <= IDLE;
          r_cmd_err <= 1'b1;
        end
        ADDR_LO: if (b.rx_valid) begin
          r_bus_addr[7:0] <= b.rx_data;
          r_state         <= (r_op == CMD_WRITE) ? DATA : BUS;
        end else if (w_expired) begin
          r_state   <= IDLE;
          r_cmd_err <= 1'b1;
        end
        DATA: if (b.rx_valid) begin
          r_bus_wdata <= b.rx_data;
          r_state     <= BUS;
        end else if (w_expired) begin
          r_state   <= IDLE;
          r_cmd_err <= 1'b1;
        end
        // bus is only granted while halted; a running CPU gets writes dropped and reads answered 0xFF
        BUS: if (!r_bus_req) begin
          if (r_cpu_halt) begin
            r_bus_req <= 1'b1;
            r_bus_we  <= (r_op == CMD_WRITE);
          end else if (r_op == CMD_WRITE) r_state <= IDLE;
          else begin
            r_tx_data <= 8'hFF;
            r_state   <= TX_SEND;
          end
        end else if (b.bus_ack) begin
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
          if (r_op == CMD_WRITE) r_state <= IDLE;
          else begin
            r_tx_data <= b.bus_rdata;
            r_state   <= TX_SEND;
          end
        end
        TX_SEND: if (!b.tx_active) begin
          r_tx_start <= 1'b1;
          r_state    <= TX_WAIT;
        end
        TX_WAIT: if (b.tx_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign b.tx_start  = r_tx_start;
  assign b.tx_data   = r_tx_data;
  assign b.bus_addr  = r_bus_addr;
  assign b.bus_wdata = r_bus_wdata;
  assign b.bus_req   = r_bus_req;
  assign b.bus_we    = r_bus_we;
  assign b.cpu_halt  = r_cpu_halt;
  assign b.cmd_err   = r_cmd_err;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed vector table plus hand sequences for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  import ie_defs::*;
  typedef struct {
    logic [7:0] byte_in;
    logic       exp_halt;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  uart_cmd_ctrl_if u();
  uart_cmd_ctrl #(.TIMEOUT_CYCLES(32'd100)) dut (.clk(clk), .rst(rst), .b(u.master));
  int checks = 0;
  int failures = 0;
  int n_req = 0;
  int n_txs = 0;
  int n_err = 0;
  int n_rx = 0;
  int tx_hold = 4;
  logic prev_req = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] cap;
  logic mock_active = 1'b0;
  logic force_busy = 1'b0;
  vec_t v [10];
  assign u.tx_active = mock_active | force_busy;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    prev_req <= u.bus_req;
    if (u.bus_req && !prev_req) n_req <= n_req + 1;
    if (u.tx_start) n_txs <= n_txs + 1;
    if (u.cmd_err) n_err <= n_err + 1;
  end
  initial begin
    u.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      if (u.tx_start) begin
        cap = u.tx_data;
        #1 mock_active = 1'b1;
        repeat (tx_hold) @(posedge clk);
        #1 u.tx_done = 1'b1;
        @(posedge clk);
        #1 u.tx_done = 1'b0;
        mock_active = 1'b0;
        rx_byte = cap;
        n_rx++;
      end
    end
  end
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    u.rx_valid = 1'b1;
    u.rx_data  = d;
    @(negedge clk);
    u.rx_valid = 1'b0;
  endtask
  task automatic wait_req(input string name);
    int n = 0;
    while (!u.bus_req && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, 32'(u.bus_req), 1);
  endtask
  task automatic ack(input logic [7:0] d);
    @(negedge clk);
    u.bus_ack   = 1'b1;
    u.bus_rdata = d;
    @(negedge clk);
    u.bus_ack = 1'b0;
  endtask
  task automatic wait_rx(input string name);
    int n0 = n_rx;
    int n = 0;
    while (n_rx == n0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, 32'(n_rx - n0), 1);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, 32'(u.tx_start), 0);
    chk({tag, "_tx_data"}, 32'(u.tx_data), 0);
    chk({tag, "_bus_addr"}, 32'(u.bus_addr), 0);
    chk({tag, "_bus_wdata"}, 32'(u.bus_wdata), 0);
    chk({tag, "_bus_req"}, 32'(u.bus_req), 0);
    chk({tag, "_bus_we"}, 32'(u.bus_we), 0);
    chk({tag, "_cpu_halt"}, 32'(u.cpu_halt), 0);
    chk({tag, "_cmd_err"}, 32'(u.cmd_err), 0);
    chk({tag, "_state"}, 32'(dut.r_state), 32'(IDLE));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nr, nt, e0, n;
    u.rx_valid = 1'b0;
    u.rx_data = 8'h00;
    u.bus_ack = 1'b0;
    u.bus_rdata = 8'h00;
    v[0] = '{8'h06, 1'b1};
    v[1] = '{8'h06, 1'b1};
    v[2] = '{8'h07, 1'b0};
    v[3] = '{8'h07, 1'b0};
    v[4] = '{8'h55, 1'b0};
    v[5] = '{8'h06, 1'b1};
    v[6] = '{8'hA0, 1'b1};
    v[7] = '{8'hFF, 1'b1};
    v[8] = '{8'h07, 1'b0};
    v[9] = '{8'h06, 1'b1};
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;
    e0 = n_err;
    nr = n_req;
    for (int i = 0; i < 10; i++) begin
      send(v[i].byte_in);
      chk($sformatf("vec%0d_halt", i), 32'(u.cpu_halt), 32'(v[i].exp_halt));
      chk($sformatf("vec%0d_state", i), 32'(dut.r_state), 32'(IDLE));
    end
    chk("vec_no_err", 32'(n_err - e0), 0);
    chk("vec_no_req", 32'(n_req - nr), 0);
    // halted write 02 80 00 A9, ack after 3 held cycles
    nr = n_req;
    send(8'h02); send(8'h80); send(8'h00); send(8'hA9);
    chk("wr_req_not_yet", 32'(u.bus_req), 0);
    @(posedge clk);
    #1 chk("wr_req_next", 32'(u.bus_req), 1);
    chk("wr_we", 32'(u.bus_we), 1);
    chk("wr_addr", 32'(u.bus_addr), 'h8000);
    chk("wr_wdata", 32'(u.bus_wdata), 'hA9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("wr_hold%0d", i), {15'd0, u.bus_req, u.bus_we, u.bus_addr}, {15'd0, 1'b1, 1'b1, 16'h8000});
    end
    ack(8'h00);
    chk("wr_req_drop", 32'(u.bus_req), 0);
    chk("wr_idle", 32'(dut.r_state), 32'(IDLE));
    chk("wr_one_req", 32'(n_req - nr), 1);
    // halted read 03 20 07, TX busy delays tx_start
    nt = n_txs;
    force_busy = 1'b1;
    send(8'h03); send(8'h20); send(8'h07);
    wait_req("rd_req");
    chk("rd_we", 32'(u.bus_we), 0);
    chk("rd_addr", 32'(u.bus_addr), 'h2007);
    ack(8'h5C);
    chk("rd_req_drop", 32'(u.bus_req), 0);
    repeat (5) @(posedge clk);
    #1 chk("rd_wait_busy", 32'(n_txs - nt), 0);
    chk("rd_state_send", 32'(dut.r_state), 32'(TX_SEND));
    @(negedge clk) force_busy = 1'b0;
    wait_rx("rd_rx");
    chk("rd_byte", 32'(rx_byte), 'h5C);
    chk("rd_one_start", 32'(n_txs - nt), 1);
    chk("rd_idle", 32'(dut.r_state), 32'(IDLE));
    // running CPU: read answered 0xFF, write dropped, no bus traffic
    send(8'h07);
    chk("run_halt", 32'(u.cpu_halt), 0);
    nr = n_req;
    send(8'h03); send(8'h00); send(8'h10);
    wait_rx("run_rd_rx");
    chk("run_rd_byte", 32'(rx_byte), 'hFF);
    send(8'h02); send(8'h00); send(8'h10); send(8'h33);
    repeat (10) @(posedge clk);
    #1 chk("run_no_req", 32'(n_req - nr), 0);
    chk("run_idle", 32'(dut.r_state), 32'(IDLE));
    // timeout after 02 80 with TIMEOUT_CYCLES=100
    e0 = n_err;
    send(8'h02); send(8'h80);
    n = 0;
    while (!u.cmd_err && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("to_cycles", 32'(n), 100);
    chk("to_idle", 32'(dut.r_state), 32'(IDLE));
    @(posedge clk);
    #1 chk("to_pulse_width", 32'(u.cmd_err), 0);
    chk("to_err_count", 32'(n_err - e0), 1);
    send(8'h06);
    chk("to_then_halt", 32'(u.cpu_halt), 1);
    // dropped byte in TX_WAIT, then reset mid-command
    tx_hold = 40;
    send(8'h03); send(8'h12); send(8'h34);
    wait_req("rst_rd_req");
    ack(8'h9A);
    n = 0;
    while (!u.tx_active && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rst_txwait", 32'(dut.r_state), 32'(TX_WAIT));
    e0 = n_err;
    send(8'h55);
    chk("drop_err", 32'(u.cmd_err), 1);
    chk("drop_state", 32'(dut.r_state), 32'(TX_WAIT));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk_reset_outputs("rst_tx");
    @(negedge clk) rst = 1'b1;
    chk("drop_err_once", 32'(n_err - e0), 1);
    send(8'h06);
    send(8'h02); send(8'hAB); send(8'hCD); send(8'h01);
    wait_req("rst_bus_req");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_bus_req_drop", 32'(u.bus_req), 0);
    @(negedge clk) rst = 1'b1;
    ack(8'h00);
    @(posedge clk);
    #1 chk("late_ack_req", 32'(u.bus_req), 0);
    chk("late_ack_idle", 32'(dut.r_state), 32'(IDLE));
    chk("late_ack_halt", 32'(u.cpu_halt), 0);
    nr = n_req;
    send(8'h06);
    send(8'h02); send(8'h00); send(8'h00); send(8'h11);
    wait_req("post_req");
    chk("post_addr", 32'(u.bus_addr), 'h0000);
    chk("post_wdata", 32'(u.bus_wdata), 'h11);
    chk("post_we", 32'(u.bus_we), 1);
    ack(8'h00);
    chk("post_req_drop", 32'(u.bus_req), 0);
    chk("post_idle", 32'(dut.r_state), 32'(IDLE));
    chk("post_one_req", 32'(n_req - nr), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
